// File: rtl/reg_file_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package reg_file_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/reg_file_wb_arbiter_slot.sv
// One-entry holding slot for a write-back source; writes to register 0 are
// acknowledged but never stored, so they can never reach the write port.
module wb_hold_slot
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_rd_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              grant_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] rd_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] data_q;
    logic              load;

    // A draining slot can be refilled on the same edge, so no bubble.
    assign ready_o = ~valid_q | grant_i;
    assign load    = in_valid_i & ready_o & (in_rd_i != ADDR_W'(REG_ZERO));

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            rd_q    <= in_rd_i;
            data_q  <= in_data_i;
        end else if (grant_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Round-robin write-back arbiter: ALU and load results share one registered
// register-file write port. Optional hazard query enabled by WB_HAZARD_EN.
module reg_file_wb_arbiter
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
`ifdef WB_HAZARD_EN
    ,
    input  logic [ADDR_W-1:0] hz_addr,
    output logic              hz_hit
`endif
);

    // Index 0 is the ALU source, index 1 the memory source (matches wb_src_t).
    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_rd     [2];
    logic [DATA_W-1:0] in_data   [2];
    logic [1:0]        slot_valid;
    logic [ADDR_W-1:0] slot_rd   [2];
    logic [DATA_W-1:0] slot_data [2];
    logic [1:0]        grant;
    logic [1:0]        ready;

    wb_src_t           last_grant_q, last_grant_d;
    logic              rf_wen_q, rf_wen_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    assign in_valid   = {mem_valid, alu_valid};
    assign in_rd[0]   = alu_rd;
    assign in_rd[1]   = mem_rd;
    assign in_data[0] = alu_data;
    assign in_data[1] = mem_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            wb_hold_slot #(
                .DATA_W(DATA_W),
                .ADDR_W(ADDR_W)
            ) u_slot (
                .clock     (clock),
                .reset     (reset),
                .in_valid_i(in_valid[gi]),
                .in_rd_i   (in_rd[gi]),
                .in_data_i (in_data[gi]),
                .grant_i   (grant[gi]),
                .ready_o   (ready[gi]),
                .valid_o   (slot_valid[gi]),
                .rd_o      (slot_rd[gi]),
                .data_o    (slot_data[gi])
            );
        end
    endgenerate

    assign alu_ready = ready[0];
    assign mem_ready = ready[1];

    always_comb begin
        grant        = slot_valid;
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = '0;
        rf_wdata_d   = '0;
        // On a tie, the source that did not win last time goes first.
        if (&slot_valid) begin
            grant = (last_grant_q == WB_SRC_ALU) ? 2'b10 : 2'b01;
        end
        if (grant[1]) begin
            last_grant_d = WB_SRC_MEM;
            rf_wen_d     = 1'b1;
            rf_waddr_d   = slot_rd[1];
            rf_wdata_d   = slot_data[1];
        end else if (grant[0]) begin
            last_grant_d = WB_SRC_ALU;
            rf_wen_d     = 1'b1;
            rf_waddr_d   = slot_rd[0];
            rf_wdata_d   = slot_data[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= WB_SRC_ALU;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_HAZARD_EN
    // Pending means held in a slot or being written on the port this cycle.
    assign hz_hit = (hz_addr != ADDR_W'(REG_ZERO)) &&
                    ((slot_valid[0] && (slot_rd[0] == hz_addr)) ||
                     (slot_valid[1] && (slot_rd[1] == hz_addr)) ||
                     (rf_wen_q && (rf_waddr_q == hz_addr)));
`endif

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Directed self-checking bench for reg_file_wb_arbiter.
module tb_reg_file_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef WB_HAZARD_EN
    logic [AW-1:0] hz_addr;
    logic          hz_hit;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    reg_file_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .alu_valid(alu_valid),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .mem_ready(mem_ready),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
`ifdef WB_HAZARD_EN
        ,
        .hz_addr  (hz_addr),
        .hz_hit   (hz_hit)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef WB_HAZARD_EN
        hz_addr = '0;
`endif
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            errors++;
            $display("FAIL reset_port: got wen=%b addr=%0d data=%h want 0/0/0", rf_wen, rf_waddr, rf_wdata);
        end
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got alu=%b mem=%b want 1/1", alu_ready, mem_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_alu();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234_5678;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b want 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: wen got %b want 0 one cycle after transfer", rf_wen);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_write: got wen=%b addr=%0d data=%h want 1/3/12345678", rf_wen, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            errors++;
            $display("FAIL single_idle: got wen=%b addr=%0d data=%h want 0/0/0", rf_wen, rf_waddr, rf_wdata);
        end
        $display("test_single_alu: write rd=3 data=12345678");
    endtask

    task automatic test_first_tie();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hA;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hB;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        checks++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL tie_ready: got alu=%b mem=%b want 0/1", alu_ready, mem_ready);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hB) begin
            errors++;
            $display("FAIL tie_first: got wen=%b addr=%0d data=%h want 1/5/b", rf_wen, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hA) begin
            errors++;
            $display("FAIL tie_second: got wen=%b addr=%0d data=%h want 1/4/a", rf_wen, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle: wen got %b want 0", rf_wen);
        end
        $display("test_first_tie: mem rd=5 then alu rd=4");
    endtask

    // Each source streams 8 items; writes must come out MEM0,ALU0,MEM1,ALU1,...
    task automatic test_contention();
        int ai = 0;
        int mi = 0;
        int wi = 0;
        logic hs_a, hs_m;
        logic [AW-1:0] exp_rd;
        logic [DW-1:0] exp_data;
        do_reset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            alu_valid = (ai < 8); alu_rd = AW'(1 + ai);  alu_data = 32'hA000_0000 | ai;
            mem_valid = (mi < 8); mem_rd = AW'(16 + mi); mem_data = 32'hB000_0000 | mi;
            if (cyc >= 1 && cyc <= 15) begin
                checks++;
                if (mem_ready !== cyc[0] || alu_ready !== ~cyc[0]) begin
                    errors++;
                    $display("FAIL contend_ready cyc=%0d: got alu=%b mem=%b want %b/%b",
                             cyc, alu_ready, mem_ready, ~cyc[0], cyc[0]);
                end
            end
            if (rf_wen === 1'b1) begin
                exp_rd   = wi[0] ? AW'(1 + wi / 2) : AW'(16 + wi / 2);
                exp_data = (wi[0] ? 32'hA000_0000 : 32'hB000_0000) | (wi / 2);
                checks++;
                if (wi >= 16 || rf_waddr !== exp_rd || rf_wdata !== exp_data) begin
                    errors++;
                    $display("FAIL contend_write #%0d: got addr=%0d data=%h want addr=%0d data=%h",
                             wi, rf_waddr, rf_wdata, exp_rd, exp_data);
                end
                wi++;
            end
            hs_a = alu_valid & alu_ready;
            hs_m = mem_valid & mem_ready;
            tick();
            if (hs_a) ai++;
            if (hs_m) mi++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        checks++;
        if (wi != 16) begin
            errors++;
            $display("FAIL contend_count: got %0d writes want 16", wi);
        end
        $display("test_contention: %0d writes observed", wi);
    endtask

    task automatic test_zero_reg();
        do_reset();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF;
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: got %b want 1", mem_ready);
        end
        tick();
        mem_valid = 1'b0;
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_not_loaded: mem_ready got %b want 1", mem_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rf_wen !== 1'b0) begin
                errors++;
                $display("FAIL zero_nowrite cyc=%0d: wen got %b want 0", i, rf_wen);
            end
            tick();
        end
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        tick();
        mem_valid = 1'b0;
        tick();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin
            errors++;
            $display("FAIL zero_follow: got wen=%b addr=%0d data=%h want 1/7/77", rf_wen, rf_waddr, rf_wdata);
        end
        $display("test_zero_reg: rd=0 absorbed, rd=7 written");
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h10;
        mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'h11;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got alu=%b mem=%b want 1/1", alu_ready, mem_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rf_wen !== 1'b0 || rf_waddr !== '0) begin
                errors++;
                $display("FAIL midreset_nowrite cyc=%0d: got wen=%b addr=%0d want 0/0", i, rf_wen, rf_waddr);
            end
            tick();
        end
        $display("test_reset_mid: pending entries discarded");
    endtask

`ifdef WB_HAZARD_EN
    task automatic test_hazard();
        do_reset();
        hz_addr = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        checks++;
        if (hz_hit !== 1'b0) begin
            errors++;
            $display("FAIL hz_before: got %b want 0", hz_hit);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if (hz_hit !== 1'b1) begin
            errors++;
            $display("FAIL hz_slot: got %b want 1", hz_hit);
        end
        hz_addr = 5'd0;
        #1;
        checks++;
        if (hz_hit !== 1'b0) begin
            errors++;
            $display("FAIL hz_zero: got %b want 0", hz_hit);
        end
        hz_addr = 5'd9;
        tick();
        checks++;
        if (hz_hit !== 1'b1 || rf_wen !== 1'b1) begin
            errors++;
            $display("FAIL hz_port: got hit=%b wen=%b want 1/1", hz_hit, rf_wen);
        end
        tick();
        checks++;
        if (hz_hit !== 1'b0) begin
            errors++;
            $display("FAIL hz_after: got %b want 0", hz_hit);
        end
        $display("test_hazard: rd=9 tracked");
    endtask
`endif

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_alu();
        test_first_tie();
        test_contention();
        test_zero_reg();
        test_reset_mid();
`ifdef WB_HAZARD_EN
        test_hazard();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
